uart_time_reporter: RTL

//  Producer side of the UART TX FIFO push interface (i_push/i_push_data).
//  On a request, snapshots the clock's time fields and streams them as ASCII
//  "HH:MM:SS\r\n" into the TX FIFO, honouring FIFO-full backpressure.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_time_reporter_bin2ascii2.sv | 19 +
 rtl/uart_time_reporter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART time reporter: ASCII codes, FSM encoding, message length.
// Defining REPORT_CSEC_EN adds a ".CC" centisecond field to the message.
package uart_pkg;

    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_DOT   = 8'h2E;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;

`ifdef REPORT_CSEC_EN
    localparam int MSG_LEN = 13;
`else
    localparam int MSG_LEN = 10;
`endif
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_SEND,
        ST_DONE
    } state_t;

endpackage

// File: rtl/uart_time_reporter_bin2ascii2.sv
// bin2ascii2: 7-bit binary value to two ASCII decimal digits, values above 99 clamp to "99".
module bin2ascii2 (
    input  logic [6:0] i_bin,
    output logic [7:0] o_tens,
    output logic [7:0] o_ones
);
    import uart_pkg::*;

    logic [6:0] w_clamp;
    logic [6:0] w_tens;
    logic [6:0] w_ones;

    assign w_clamp = (i_bin > 7'd99) ? 7'd99 : i_bin;
    assign w_tens  = w_clamp / 7'd10;
    assign w_ones  = w_clamp % 7'd10;
    assign o_tens  = ASC_0 + {1'b0, w_tens};
    assign o_ones  = ASC_0 + {1'b0, w_ones};

endmodule

// File: rtl/uart_time_reporter.sv
// Snapshots the time fields on request and streams "HH:MM:SS[.CC]\r\n" into the UART TX FIFO.
// REPORT_CSEC_EN enables the centisecond field (13-byte message instead of 10).
module uart_time_reporter (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req,
    input  logic [4:0] i_hour,
    input  logic [5:0] i_min,
    input  logic [5:0] i_sec,
    input  logic [6:0] i_csec,
    input  logic       i_full,
    output logic       o_push,
    output logic [7:0] o_push_data,
    output logic       o_busy,
    output logic       o_done
);
    import uart_pkg::*;

    state_t                    r_state;
    logic [IDX_W-1:0]          r_idx;
    logic                      r_pending;
    logic [4:0]                r_hour;
    logic [5:0]                r_min;
    logic [5:0]                r_sec;
    logic [MSG_LEN-1:0][7:0]   r_msg;
    logic                      r_busy;
    logic                      r_done;

    logic [7:0]                w_h1, w_h0, w_m1, w_m0, w_s1, w_s0;
    logic [MSG_LEN-1:0][7:0]   w_msg;
    logic                      w_push;
    logic                      w_last;

    bin2ascii2 u_hour (.i_bin({2'b00, r_hour}), .o_tens(w_h1), .o_ones(w_h0));
    bin2ascii2 u_min  (.i_bin({1'b0, r_min}),   .o_tens(w_m1), .o_ones(w_m0));
    bin2ascii2 u_sec  (.i_bin({1'b0, r_sec}),   .o_tens(w_s1), .o_ones(w_s0));

`ifdef REPORT_CSEC_EN
    logic [6:0] r_csec;
    logic [7:0] w_c1, w_c0;
    bin2ascii2 u_csec (.i_bin(r_csec), .o_tens(w_c1), .o_ones(w_c0));
`else
    logic w_unused_csec;
    assign w_unused_csec = ^i_csec;
`endif

    // Element 0 is the first byte on the wire.
    always_comb begin
        w_msg    = '0;
        w_msg[0] = w_h1;
        w_msg[1] = w_h0;
        w_msg[2] = ASC_COLON;
        w_msg[3] = w_m1;
        w_msg[4] = w_m0;
        w_msg[5] = ASC_COLON;
        w_msg[6] = w_s1;
        w_msg[7] = w_s0;
`ifdef REPORT_CSEC_EN
        w_msg[8]  = ASC_DOT;
        w_msg[9]  = w_c1;
        w_msg[10] = w_c0;
        w_msg[11] = ASC_CR;
        w_msg[12] = ASC_LF;
`else
        w_msg[8]  = ASC_CR;
        w_msg[9]  = ASC_LF;
`endif
    end

    assign w_push      = (r_state == ST_SEND) && !i_full;
    assign w_last      = (r_idx == IDX_W'(MSG_LEN - 1));
    assign o_push      = w_push;
    assign o_push_data = (r_state == ST_SEND) ? r_msg[r_idx] : 8'h00;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_pending <= 1'b0;
            r_hour    <= '0;
            r_min     <= '0;
            r_sec     <= '0;
`ifdef REPORT_CSEC_EN
            r_csec    <= '0;
`endif
            r_msg     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req) begin
                        r_hour  <= i_hour;
                        r_min   <= i_min;
                        r_sec   <= i_sec;
`ifdef REPORT_CSEC_EN
                        r_csec  <= i_csec;
`endif
                        r_busy  <= 1'b1;
                        r_state <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    r_msg   <= w_msg;
                    r_idx   <= '0;
                    r_state <= ST_SEND;
                    if (i_req) r_pending <= 1'b1;
                end
                ST_SEND: begin
                    if (i_req) r_pending <= 1'b1;
                    if (w_push) begin
                        r_idx <= r_idx + 1'b1;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_done <= 1'b0;
                    // A request arriving in this cycle is served just like a pending one.
                    if (r_pending || i_req) begin
                        r_hour    <= i_hour;
                        r_min     <= i_min;
                        r_sec     <= i_sec;
`ifdef REPORT_CSEC_EN
                        r_csec    <= i_csec;
`endif
                        r_pending <= 1'b0;
                        r_state   <= ST_CONV;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
